fetch_unit: RTL

Instruction fetch front end for the 32-bit RISC-V pipeline. It generates the PC, issues in-order word requests to instruction memory over a valid/ready request channel, and buffers returned instructions in a small queue feeding Decode. It is the consumer of the Execute-stage branch/jump resolution: a taken branch redirects the PC and discards every wrong-path instruction, whether in flight or queued.

---
 rtl/fetch_unit_if.sv | 49 ++++
 rtl/fetch_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit signal bundle: instruction-memory request/response, Execute redirect and Decode-side outputs.
// master = fetch_unit, slave = memory / pipeline environment.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall_d;
    logic        instr_valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        fetch_fault;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_target,
        input  stall_d,
        output instr_valid_d,
        output instr_d,
        output pc_d,
        output pc_plus4_d,
        output fetch_fault
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_target,
        output stall_d,
        input  instr_valid_d,
        input  instr_d,
        input  pc_d,
        input  pc_plus4_d,
        input  fetch_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited in-order memory requests and a Decode queue.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirects raise a sticky fetch_fault).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master fif
);

    localparam int unsigned   PTR_W   = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned   CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FQ_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [31:0]      pc_r;
    logic             epoch_r;
    logic             fault_r;
    logic [CNT_W-1:0] outst_r;
    logic [CNT_W-1:0] count_r;

    logic             tag_epoch_r [FQ_DEPTH];
    logic [31:0]      tag_pc_r    [FQ_DEPTH];
    logic [PTR_W-1:0] tag_wptr_r;
    logic [PTR_W-1:0] tag_rptr_r;

    logic [31:0]      q_instr_r [FQ_DEPTH];
    logic [31:0]      q_pc_r    [FQ_DEPTH];
    logic [31:0]      q_pc4_r   [FQ_DEPTH];
    logic [PTR_W-1:0] q_wptr_r;
    logic [PTR_W-1:0] q_rptr_r;

    logic [CNT_W:0]   credit_sum_s;
    logic             req_valid_s;
    logic             accept_s;
    logic             rsp_pop_s;
    logic             rsp_keep_s;
    logic             deq_s;
    logic [31:0]      redirect_pc_s;
    logic             redirect_bad_s;

    // Issue credit, handshake qualifiers and response epoch filter.
    always_comb begin
        credit_sum_s = {1'b0, outst_r} + {1'b0, count_r};
        req_valid_s  = !reset && !fault_r && (credit_sum_s < DEPTH_C);
        accept_s     = req_valid_s && fif.imem_req_ready;
        // A response with nothing outstanding (e.g. a pre-reset request) is dropped.
        rsp_pop_s    = fif.imem_rsp_valid && (outst_r != CNT_ZERO);
        rsp_keep_s   = rsp_pop_s && (tag_epoch_r[tag_rptr_r] == epoch_r) && !fif.redirect_valid;
        deq_s        = (count_r != CNT_ZERO) && !fif.stall_d && !fif.redirect_valid;
    end

    // Redirect target qualification.
    always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
        redirect_pc_s  = fif.redirect_target;
        redirect_bad_s = (fif.redirect_target[1:0] != 2'b00);
`else
        redirect_pc_s  = {fif.redirect_target[31:2], 2'b00};
        redirect_bad_s = 1'b0;
`endif
    end

    // PC, epoch, fault flag and outstanding-request bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            epoch_r    <= 1'b0;
            fault_r    <= 1'b0;
            outst_r    <= CNT_ZERO;
            tag_wptr_r <= '0;
            tag_rptr_r <= '0;
        end else begin
            if (fif.redirect_valid) begin
                epoch_r <= ~epoch_r;
                fault_r <= redirect_bad_s;
                if (!redirect_bad_s) begin
                    pc_r <= redirect_pc_s;
                end else if (accept_s) begin
                    pc_r <= pc_r + 32'd4;
                end
            end else if (accept_s) begin
                pc_r <= pc_r + 32'd4;
            end

            if (accept_s) begin
                tag_wptr_r <= tag_wptr_r + PTR_ONE;
            end
            if (rsp_pop_s) begin
                tag_rptr_r <= tag_rptr_r + PTR_ONE;
            end

            case ({accept_s, rsp_pop_s})
                2'b10:   outst_r <= outst_r + CNT_ONE;
                2'b01:   outst_r <= outst_r - CNT_ONE;
                default: outst_r <= outst_r;
            endcase
        end
    end

    // Tag FIFO storage; entries are only read while a request is outstanding.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            // Tagged with the pre-toggle epoch, so a same-cycle redirect marks it stale.
            tag_epoch_r[tag_wptr_r] <= epoch_r;
            tag_pc_r[tag_wptr_r]    <= pc_r;
        end
    end

    // Instruction queue: registered enqueue of kept responses, Decode pops, redirect flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_wptr_r <= '0;
            q_rptr_r <= '0;
            count_r  <= CNT_ZERO;
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                q_instr_r[i] <= 32'h0000_0000;
                q_pc_r[i]    <= 32'h0000_0000;
                q_pc4_r[i]   <= 32'h0000_0000;
            end
        end else if (fif.redirect_valid) begin
            q_rptr_r <= q_wptr_r;
            count_r  <= CNT_ZERO;
        end else begin
            if (rsp_keep_s) begin
                q_instr_r[q_wptr_r] <= fif.imem_rsp_data;
                q_pc_r[q_wptr_r]    <= tag_pc_r[tag_rptr_r];
                q_pc4_r[q_wptr_r]   <= tag_pc_r[tag_rptr_r] + 32'd4;
                q_wptr_r            <= q_wptr_r + PTR_ONE;
            end
            if (deq_s) begin
                q_rptr_r <= q_rptr_r + PTR_ONE;
            end
            case ({rsp_keep_s, deq_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign fif.imem_req_valid = req_valid_s;
    assign fif.imem_req_addr  = pc_r;
    assign fif.instr_valid_d  = (count_r != CNT_ZERO);
    assign fif.instr_d        = q_instr_r[q_rptr_r];
    assign fif.pc_d           = q_pc_r[q_rptr_r];
    assign fif.pc_plus4_d     = q_pc4_r[q_rptr_r];
    assign fif.fetch_fault    = fault_r;

endmodule
